pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and stall sequencer for the 5-stage pipeline. Generates the enable/flush pair for every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC write enable. It resolves cache waits, load-use hazards, EX-stage control redirects and halt drain from one priority-ordered decision per cycle. It sits beside the datapath, driving the latches' `enable` and `flush` inputs directly.

## Interface

Parameters:
- `REG_W`, default 5: register-index width.
- `CNT_W`, default 32: performance counter width (used only with `PIPE_PERF_EN`).

Ports:
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  synchronous, active-high reset.
- `ihit`  in  1  instruction fetch for the current PC is complete this cycle.
- `dhit`  in  1  data access in MEM is complete this cycle.
- `mem_dreq`  in  1  MEM-stage instruction has `dREN|dWEN` set.
- `mem_halt`  in  1  halt instruction is in MEM.
- `ex_dREN`  in  1  EX-stage instruction is a load.
- `ex_wsel`  in  REG_W  EX-stage destination register.
- `id_rs`, `id_rt`  in  REG_W  ID-stage source registers.
- `id_uses_rt`  in  1  ID instruction reads `rt` as a source.
- `ex_redirect`  in  1  EX resolved a taken branch or jump (pc_select ≠ NEXT).
- `pc_enable`  out  1  PC register loads its next value.
- `ifid_enable`, `idex_enable`, `exmem_enable`, `memwb_enable`  out  1 each  latch advances.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  latch loads a bubble. Flush overrides enable.
- `halt_out`  out  1  pipeline fully drained and stopped.
- `cyc_cnt`, `stall_cnt`, `flush_cnt`  out  CNT_W each  present only with `PIPE_PERF_EN`.

## Operation

FSM states are RUN, DWAIT, DRAIN and HALTED. Reset state is RUN.

Load-use hazard `lu` is defined as `ex_dREN && ex_wsel≠0 && (ex_wsel==id_rs || (id_uses_rt && ex_wsel==id_rt))`.

In RUN and DWAIT, the first matching rule below applies. All unnamed enables are 1 and all unnamed flushes are 0.
1. `mem_halt`:
   - `pc_enable`=0.
   - `ifid_flush`, `idex_flush`, `exmem_flush`=1.
   - `memwb_enable`=1.
   - Next state DRAIN.
   - `mem_dreq` is ignored.
2. `mem_dreq && !dhit`:
   - All enables 0.
   - `memwb_flush`=1 (no duplicate writeback).
   - Next state DWAIT.
3. `ex_redirect`:
   - `pc_enable`=1 (loads target).
   - `ifid_flush`=1 and `idex_flush`=1.
   - EX/MEM and MEM/WB advance.
   - `lu` and `ihit` are ignored.
4. `lu`:
   - `pc_enable`=0 and `ifid_enable`=0.
   - `idex_flush`=1.
   - EX/MEM and MEM/WB advance.
5. `!ihit`:
   - `pc_enable`=0.
   - `ifid_flush`=1.
   - ID/EX, EX/MEM and MEM/WB advance.
6. Otherwise all enables are 1. Next state is RUN.

Whenever rules 3–6 apply, the next state is RUN. A cycle in DWAIT with `dhit`=1 is therefore the release cycle.

DRAIN:
- All enables 0.
- `ifid_flush`, `idex_flush`, `exmem_flush`=1.
- Always moves to HALTED.

HALTED:
- All enables 0. All flushes 0.
- `halt_out`=1.
- Only `RST` leaves this state.

## Timing

- Enables and flushes are combinational from inputs and state; there is zero-cycle latency to the latches. `halt_out` is decoded from the registered state.
- While `RST`=1:
  - All enables are 0 and all four flushes are 1.
  - `halt_out`=0 and the counters are 0.
  - The state is RUN on the first edge after release.
- Halt timing: `mem_halt` asserted in cycle N gives DRAIN in cycle N+1, with `halt_out`=1 from cycle N+2 onward.
- A redirect held in EX during a DWAIT freeze is re-evaluated on the release cycle; it is never lost.
- A load-use stall lasts exactly 1 cycle when `ihit`, `dhit` and the redirect condition are quiet.
- A stall caused by `!ihit` repeats every cycle until `ihit` is seen.
- RST asserted in any state, including mid-DWAIT or DRAIN, wins on the next edge.

## Configuration

`PIPE_PERF_EN` defined:
- `cyc_cnt` increments on every non-reset cycle outside HALTED.
- `stall_cnt` increments on every cycle where rule 2, 4 or 5 applies.
- `flush_cnt` increments on every cycle where rule 3 applies.
- All three counters saturate at all-ones and are cleared by `RST`.

`PIPE_PERF_EN` undefined:
- The counter ports and their logic are absent.
- All other behaviour is identical.

## Test plan

- Reset:
  - Stimulus: `RST`=1 for 2 cycles, with `ihit`=`dhit`=1.
  - During reset, all four flushes are 1, all enables are 0 and `halt_out`=0.
  - On the first cycle after release, all enables are 1.
- Load-use:
  - Stimulus: `ex_dREN`=1, `ex_wsel`=5, `id_rs`=5.
  - Exactly one cycle with `pc_enable`=0, `ifid_enable`=0 and `idex_flush`=1.
  - Repeat with `ex_wsel`=0: no stall.
- D-cache wait:
  - Stimulus: `mem_dreq`=1 with `dhit`=0 for 3 cycles, then `dhit`=1.
  - For 3 cycles, all enables are 0 and `memwb_flush`=1; the state is DWAIT.
  - The release cycle advances all latches.
- Redirect priority:
  - Stimulus: `ex_redirect`=1, `lu`=1 and `ihit`=0 in the same cycle. The result is `pc_enable`=1, `ifid_flush`=1 and `idex_flush`=1.
  - Stimulus: `ex_redirect`=1 during a DWAIT. The redirect is applied on the release cycle.
- Halt:
  - Stimulus: `mem_halt` in cycle 10. Cycle 10 has `memwb_enable`=1; cycle 11 is DRAIN.
  - `halt_out`=1 from cycle 12.
  - Holds in HALTED for 20 cycles despite inputs; `RST` returns the block to RUN.
- With `PIPE_PERF_EN`:
  - Stimulus: the scenario above with 3 D-cache wait cycles and 1 load-use stall gives `stall_cnt`=4.
  - 2 redirects give `flush_cnt`=2.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and latch controls shared by the datapath and pipeline_ctrl.
// Ports (signals):
//   datapath -> ctrl : ihit, dhit, mem_dreq, mem_halt, ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt, ex_redirect
//   ctrl -> datapath : pc_enable, {ifid,idex,exmem,memwb}_{enable,flush}, halt_out
// Modports: master = controller side, slave = datapath side.
interface pipeline_ctrl_if #(parameter int REG_W = 5);
    logic             ihit, dhit, mem_dreq, mem_halt, ex_dREN, id_uses_rt, ex_redirect;
    logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
    logic             pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out;

    modport master (
        input  ihit, dhit, mem_dreq, mem_halt, ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt, ex_redirect,
        output pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out
    );
    modport slave (
        output ihit, dhit, mem_dreq, mem_halt, ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt, ex_redirect,
        input  pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall sequencer driving the enable/flush of every pipeline latch and the PC.
// Ports:
//   CLK         rising-edge clock
//   RST         synchronous active-high reset
//   bus         pipeline_ctrl_if.master (hazard inputs in, latch enables/flushes and halt_out out)
//   cyc_cnt, stall_cnt, flush_cnt  saturating performance counters (only with PIPE_PERF_EN)
// Build option: define PIPE_PERF_EN to add the performance counters and the CNT_W parameter.
module pipeline_ctrl #(
    parameter int REG_W = 5
`ifdef PIPE_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic            CLK,
    input  logic            RST,
    pipeline_ctrl_if.master bus
`ifdef PIPE_PERF_EN
    , output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

    state_t           state, next_state;
    logic [REG_W-1:0] wsel;
    logic             lu, stall, redir;
    // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}
    logic [4:0]       en;
    logic [3:0]       fl;

    assign wsel = bus.ex_wsel;
    assign lu   = bus.ex_dREN && wsel != '0 &&
                  (wsel == bus.id_rs || (bus.id_uses_rt && wsel == bus.id_rt));

    always_ff @(posedge CLK) begin
        if (RST) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        en         = 5'b11111;
        fl         = 4'b0000;
        next_state = state;
        stall      = 1'b0;
        redir      = 1'b0;
        if (RST) begin
            en = 5'b00000;
            fl = 4'b1111;
        end else begin
            case (state)
                RUN, DWAIT: begin
                    next_state = RUN;
                    if (bus.mem_halt) begin
                        en         = 5'b01111;
                        fl         = 4'b1110;
                        next_state = DRAIN;
                    end else if (bus.mem_dreq && !bus.dhit) begin
                        // freeze everything; bubble MEM/WB so the stuck access is not written back twice
                        en         = 5'b00000;
                        fl         = 4'b0001;
                        next_state = DWAIT;
                        stall      = 1'b1;
                    end else if (bus.ex_redirect) begin
                        fl    = 4'b1100;
                        redir = 1'b1;
                    end else if (lu) begin
                        en    = 5'b00111;
                        fl    = 4'b0100;
                        stall = 1'b1;
                    end else if (!bus.ihit) begin
                        en    = 5'b01111;
                        fl    = 4'b1000;
                        stall = 1'b1;
                    end
                end
                DRAIN: begin
                    en         = 5'b00000;
                    fl         = 4'b1110;
                    next_state = HALTED;
                end
                default: en = 5'b00000;
            endcase
        end
    end

    assign {bus.pc_enable, bus.ifid_enable, bus.idex_enable, bus.exmem_enable, bus.memwb_enable} = en;
    assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush} = fl;
    assign bus.halt_out = !RST && state == HALTED;

`ifdef PIPE_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != HALTED && ~&cyc_cnt) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (stall && ~&stall_cnt)         stall_cnt <= stall_cnt + CNT_W'(1);
            if (redir && ~&flush_cnt)         flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table vectors, directed corner sequences and random stimulus against a rule-level model.
module tb_pipeline_ctrl;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pipeline_ctrl_if #(.REG_W(5)) bus();
`ifdef PIPE_PERF_EN
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
    pipeline_ctrl #(.REG_W(5), .CNT_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    pipeline_ctrl #(.REG_W(5)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

    typedef struct {
        logic       rst, ihit, dhit, dreq, halt, dren;
        logic [4:0] wsel, rs, rt;
        logic       urt, redir;
    } in_t;
    typedef struct {
        in_t        i;
        logic [9:0] exp;
    } vec_t;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, halt_out}
    localparam logic [9:0] O_RST   = 10'b00000_1111_0;
    localparam logic [9:0] O_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] O_HALT  = 10'b01111_1110_0;
    localparam logic [9:0] O_DW    = 10'b00000_0001_0;
    localparam logic [9:0] O_REDIR = 10'b11111_1100_0;
    localparam logic [9:0] O_LU    = 10'b00111_0100_0;
    localparam logic [9:0] O_IMISS = 10'b01111_1000_0;
    localparam logic [9:0] O_DRAIN = 10'b00000_1110_0;
    localparam logic [9:0] O_HLTD  = 10'b00000_0000_1;

    int errors = 0;
    int checks = 0;
    int ph = 0;  // model phase: 0 running, 1 draining, 2 halted
    logic [31:0] m_cyc = 0, m_stall = 0, m_flush = 0;

    function automatic in_t mk(logic rst, logic ihit, logic dhit, logic dreq, logic halt, logic dren,
                               logic [4:0] wsel, logic [4:0] rs, logic [4:0] rt, logic urt, logic redir);
        in_t v;
        v.rst = rst; v.ihit = ihit; v.dhit = dhit; v.dreq = dreq; v.halt = halt; v.dren = dren;
        v.wsel = wsel; v.rs = rs; v.rt = rt; v.urt = urt; v.redir = redir;
        return v;
    endfunction

    function automatic int rule_of(in_t v);
        logic lu;
        lu = v.dren && v.wsel != 0 && (v.wsel == v.rs || (v.urt && v.wsel == v.rt));
        if (v.halt) return 1;
        if (v.dreq && !v.dhit) return 2;
        if (v.redir) return 3;
        if (lu) return 4;
        if (!v.ihit) return 5;
        return 6;
    endfunction

    function automatic logic [9:0] model(in_t v);
        int r;
        r = rule_of(v);
        if (v.rst) return O_RST;
        if (ph == 2) return O_HLTD;
        if (ph == 1) return O_DRAIN;
        return {r == 3 || r == 6, r inside {1, 3, 5, 6}, r != 2, r != 2, r != 2,
                r inside {1, 3, 5}, r inside {1, 3, 4}, r == 1, r == 2, 1'b0};
    endfunction

    function automatic logic [9:0] outs();
        return {bus.pc_enable, bus.ifid_enable, bus.idex_enable, bus.exmem_enable, bus.memwb_enable,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush, bus.halt_out};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, got, exp);
        end
    endtask

    task automatic step(input in_t v, input string n, output logic [9:0] got);
        int r;
        RST = v.rst; bus.ihit = v.ihit; bus.dhit = v.dhit; bus.mem_dreq = v.dreq; bus.mem_halt = v.halt;
        bus.ex_dREN = v.dren; bus.ex_wsel = v.wsel; bus.id_rs = v.rs; bus.id_rt = v.rt;
        bus.id_uses_rt = v.urt; bus.ex_redirect = v.redir;
        #1;
        got = outs();
        chk({n, "/model"}, {22'd0, got}, {22'd0, model(v)});
`ifdef PIPE_PERF_EN
        chk({n, "/cyc_cnt"}, cyc_cnt, m_cyc);
        chk({n, "/stall_cnt"}, stall_cnt, m_stall);
        chk({n, "/flush_cnt"}, flush_cnt, m_flush);
`endif
        @(posedge CLK);
        r = rule_of(v);
        if (v.rst) begin
            m_cyc = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (ph != 2 && m_cyc != '1) m_cyc++;
            if (ph == 0 && r inside {2, 4, 5} && m_stall != '1) m_stall++;
            if (ph == 0 && r == 3 && m_flush != '1) m_flush++;
        end
        ph = v.rst ? 0 : ph == 2 ? 2 : ph == 1 ? 2 : (r == 1 ? 1 : 0);
        @(negedge CLK);
    endtask

    vec_t tbl[23];
    in_t  q, rs_v, dw, ld;
    logic [9:0] got;
    logic [31:0] s0, f0;

    initial begin
        q    = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        rs_v = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        dw   = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        ld   = mk(0, 1, 1, 0, 0, 1, 5, 5, 0, 0, 0);
        tbl[0]  = '{rs_v, O_RST};
        tbl[1]  = '{rs_v, O_RST};
        tbl[2]  = '{q, O_RUN};
        tbl[3]  = '{ld, O_LU};
        tbl[4]  = '{q, O_RUN};
        tbl[5]  = '{mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0), O_RUN};
        tbl[6]  = '{mk(0, 1, 1, 0, 0, 1, 7, 1, 7, 0, 0), O_RUN};
        tbl[7]  = '{mk(0, 1, 1, 0, 0, 1, 7, 1, 7, 1, 0), O_LU};
        tbl[8]  = '{mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), O_IMISS};
        tbl[9]  = '{mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), O_IMISS};
        tbl[10] = '{mk(0, 0, 1, 0, 0, 1, 5, 5, 0, 0, 1), O_REDIR};
        tbl[11] = '{dw, O_DW};
        tbl[12] = '{dw, O_DW};
        tbl[13] = '{dw, O_DW};
        tbl[14] = '{mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), O_RUN};
        tbl[15] = '{mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1), O_DW};
        tbl[16] = '{mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1), O_REDIR};
        tbl[17] = '{mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), O_HALT};
        tbl[18] = '{q, O_DRAIN};
        tbl[19] = '{q, O_HLTD};
        tbl[20] = '{mk(0, 0, 0, 1, 1, 1, 3, 3, 3, 1, 1), O_HLTD};
        tbl[21] = '{rs_v, O_RST};
        tbl[22] = '{q, O_RUN};
        @(negedge CLK);
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].i, $sformatf("tbl%0d", i), got);
            chk($sformatf("tbl%0d", i), {22'd0, got}, {22'd0, tbl[i].exp});
        end

        // halt issued in cycle 10 after reset release
        step(rs_v, "h_rst", got);
        for (int c = 0; c < 10; c++) step(q, "h_pre", got);
        step(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0), "h_c10", got);
        chk("h_c10_memwb_en", {31'd0, got[5]}, 32'd1);
        step(q, "h_c11", got);
        chk("h_c11_drain", {22'd0, got}, {22'd0, O_DRAIN});
        for (int c = 0; c < 20; c++) begin
            step(mk(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    1, 2, 2, 2, 1, $urandom_range(0, 1)), "h_hold", got);
            chk("h_hold_halted", {22'd0, got}, {22'd0, O_HLTD});
        end
        step(rs_v, "h_rst2", got);
        step(q, "h_run", got);
        chk("h_after_rst", {22'd0, got}, {22'd0, O_RUN});

        // reset in the middle of DWAIT and of DRAIN
        step(dw, "rd_dw", got);
        step(rs_v, "rd_rst", got);
        step(q, "rd_run", got);
        chk("rst_mid_dwait", {22'd0, got}, {22'd0, O_RUN});
        step(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0), "rh_halt", got);
        step(rs_v, "rh_rst", got);
        step(q, "rh_run", got);
        chk("rst_mid_drain", {22'd0, got}, {22'd0, O_RUN});

`ifdef PIPE_PERF_EN
        s0 = stall_cnt;
        f0 = flush_cnt;
        for (int c = 0; c < 3; c++) step(dw, "p_dw", got);
        step(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "p_rel", got);
        step(ld, "p_lu", got);
        step(q, "p_q", got);
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1), "p_r1", got);
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1), "p_r2", got);
        chk("perf_stall4", stall_cnt - s0, 32'd4);
        chk("perf_flush2", flush_cnt - f0, 32'd2);
`endif

        for (int c = 0; c < 400; c++) begin
            in_t r;
            r = mk($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 1), $urandom_range(0, 4) == 0);
            step(r, "rand", got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
